gpio_serial_config_loader: RTL and testbench
============================================

Name: gpio_serial_config_loader

Overview:
- Sequences the per-pad configuration of the user-project GPIO pads in the padframe.
- On a start request it fetches one configuration word per pad from a word-addressed source (housekeeping register file) and shifts it out on a serial chain (serial_clock/serial_data) to the per-pad control blocks.
- Then pulses serial_load so all pads latch their new mode, drive-mode and enable bits at the same time.
- Sits between housekeeping and the chain of pad control blocks that feed mprj_io_dm, mprj_io_oeb, mprj_io_inp_dis and related inputs.

Parameters:
- NPADS, 38, number of pads on the chain (matches MPRJ_IO_PADS).
- WORD_BITS, 13, configuration bits per pad.
- CLKDIV, 2, clk cycles per serial_clock phase; legal values are 1..255.
- IDXW, 6, width of cfg_idx; must satisfy 2^IDXW >= NPADS.

Ports:
- clk  input  1  system clock.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to (re)load the whole chain; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until DONE is left.
- done  output  1  one-cycle pulse when the load sequence completes.
- cfg_idx  output  IDXW  registered index of the pad word being fetched.
- cfg_word  input  WORD_BITS  configuration word for cfg_idx; must be valid in the FETCH cycle (zero-latency combinational read).
- serial_clock  output  1  chain shift clock; data is captured on its rising edge.
- serial_data  output  1  chain shift data.
- serial_load  output  1  chain latch strobe, active high.

Behaviour:
- Reset values: busy=0, done=0, cfg_idx=0, serial_clock=0, serial_data=0, serial_load=0, state=IDLE, all counters 0.
- Asserting resetn low mid-operation aborts the sequence immediately. No serial_load is issued, so the pads keep their previously latched configuration.
- All outputs are registered.
- Pad order: highest index first. cfg_idx goes NPADS-1 down to 0, so that pad 0's word is the last one shifted and sits nearest the chain input.
- Bit order within a word: MSB first.
- FSM states: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE:
  - start=1 -> FETCH, with cfg_idx=NPADS-1 and busy=1.
  - start=0 -> stay in IDLE.
- FETCH (1 cycle): capture cfg_word into the shift register, set bitcnt=WORD_BITS-1, then go to SHIFT_LO.
- SHIFT_LO (CLKDIV cycles):
  - serial_clock=0.
  - serial_data = shift register MSB, valid from the first SHIFT_LO cycle.
  - Then go to SHIFT_HI.
- SHIFT_HI (CLKDIV cycles): serial_clock=1 and serial_data held stable. On exit:
  - bitcnt!=0: shift left, decrement bitcnt, go to SHIFT_LO.
  - bitcnt==0 and cfg_idx!=0: decrement cfg_idx, go to FETCH.
  - bitcnt==0 and cfg_idx==0: go to LOAD.
- LOAD (CLKDIV cycles): serial_clock=0, serial_load=1, serial_data=0. Then go to DONE.
- DONE (1 cycle): done=1, busy=1, serial_load=0. Then go to IDLE, where busy=0.
- start while not in IDLE, including the DONE cycle, is ignored and not queued.
- Divider counter runs 0..CLKDIV-1, restarts on every state entry, and never wraps silently.
- Total latency from start-accept to done pulse: NPADS*(1 + 2*CLKDIV*WORD_BITS) + CLKDIV + 1 cycles.
- serial_clock never rises in the same cycle that serial_data changes.

Test Plan:
1. Reset: resetn=0 with start toggling -> all outputs 0; after release, state stays IDLE, busy=0.
2. NPADS=2, WORD_BITS=13, CLKDIV=1, words pad1=0x1803, pad0=0x0402, start pulse:
   - cfg_idx goes 1 then 0.
   - serial_data at the 26 rising edges of serial_clock = 1_1000_0000_0011 then 0_0100_0000_0010.
   - serial_load high 1 cycle.
   - done exactly 56 cycles after start-accept.
3. Default NPADS=38, CLKDIV=2, cfg_word = pad index:
   - Chain model latches word i in pad i after serial_load.
   - done after 38*53+3=2017 cycles.
4. start re-asserted during SHIFT_HI and during DONE -> ignored; exactly one done pulse; a later start in IDLE runs a full second sequence.
5. resetn pulsed low mid-shift (pad 20, bit 6) -> outputs 0 asynchronously; no serial_load pulse; the chain model retains its previous latched values.
6. CLKDIV=3 -> serial_clock low/high phases exactly 3 cycles each; serial_data stable for all 3 high cycles; no serial_data edge coincides with a serial_clock rising edge.

Source files
------------

// File: rtl/gpio_serial_config_loader.sv
// Shifts one config word per GPIO pad onto the padframe serial chain,
// highest pad first and MSB first, then pulses serial_load to latch all pads.
module gpio_serial_config_loader #(
    parameter int NPADS     = 38,
    parameter int WORD_BITS = 13,
    parameter int CLKDIV    = 2,
    parameter int IDXW      = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [IDXW-1:0]      cfg_idx,
    input  logic [WORD_BITS-1:0] cfg_word,
    output logic                 serial_clock,
    output logic                 serial_data,
    output logic                 serial_load
);

    localparam int BCW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
    localparam logic [7:0]      DIV_LAST = 8'(CLKDIV - 1);
    localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NPADS - 1);
    localparam logic [BCW-1:0]  BIT_TOP  = BCW'(WORD_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        DONE
    } state_t;

    state_t               state;
    logic [WORD_BITS-1:0] shreg;
    logic [WORD_BITS-1:0] shnext;
    logic [BCW-1:0]       bitcnt;
    logic [7:0]           divcnt;
    logic                 div_end;

    assign shnext  = shreg << 1;
    assign div_end = (divcnt == DIV_LAST);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            busy         <= 1'b0;
            done         <= 1'b0;
            cfg_idx      <= '0;
            serial_clock <= 1'b0;
            serial_data  <= 1'b0;
            serial_load  <= 1'b0;
            shreg        <= '0;
            bitcnt       <= '0;
            divcnt       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state   <= FETCH;
                        cfg_idx <= IDX_TOP;
                        busy    <= 1'b1;
                    end
                end
                FETCH: begin
                    shreg        <= cfg_word;
                    bitcnt       <= BIT_TOP;
                    serial_data  <= cfg_word[WORD_BITS-1];
                    serial_clock <= 1'b0;
                    divcnt       <= '0;
                    state        <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (div_end) begin
                        divcnt       <= '0;
                        serial_clock <= 1'b1;
                        state        <= SHIFT_HI;
                    end else begin
                        divcnt <= divcnt + 8'd1;
                    end
                end
                SHIFT_HI: begin
                    if (div_end) begin
                        divcnt       <= '0;
                        serial_clock <= 1'b0;
                        if (bitcnt != '0) begin
                            shreg       <= shnext;
                            serial_data <= shnext[WORD_BITS-1];
                            bitcnt      <= bitcnt - 1'b1;
                            state       <= SHIFT_LO;
                        end else if (cfg_idx != '0) begin
                            cfg_idx <= cfg_idx - 1'b1;
                            state   <= FETCH;
                        end else begin
                            serial_load <= 1'b1;
                            serial_data <= 1'b0;
                            state       <= LOAD;
                        end
                    end else begin
                        divcnt <= divcnt + 8'd1;
                    end
                end
                LOAD: begin
                    if (div_end) begin
                        divcnt      <= '0;
                        serial_load <= 1'b0;
                        done        <= 1'b1;
                        state       <= DONE;
                    end else begin
                        divcnt <= divcnt + 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gpio_serial_config_loader.sv
// Three loader instances with different chain sizes and dividers, checked
// against a pad-chain model and word-table expectations.
module tb_gpio_serial_config_loader;

    function automatic int np_of(input int k);
        return (k == 0) ? 2 : (k == 1) ? 38 : 4;
    endfunction

    function automatic int cd_of(input int k);
        return (k == 0) ? 1 : (k == 1) ? 2 : 3;
    endfunction

    function automatic int lat_of(input int k);
        return np_of(k) * (1 + 2 * cd_of(k) * 13) + cd_of(k) + 1;
    endfunction

    logic        clk;
    logic        resetn;
    logic [2:0]  start, busy, done, sc, sd, sl;
    logic [5:0]  idx [3];
    logic [12:0] cw  [3];

    logic [12:0]  words [3][38];
    logic [12:0]  prev_w [38];
    logic [493:0] chain [3];
    logic [493:0] latched [3];

    int edges [3], hi_len [3], lo_len [3], ld_len [3];
    int loads [3], dones [3];
    logic [2:0] psc, psd, psl, pbusy;
    logic [5:0] pidx [3];

    int n_cmp = 0;
    int n_err = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        gpio_serial_config_loader #(
            .NPADS(np_of(g)),
            .WORD_BITS(13),
            .CLKDIV(cd_of(g)),
            .IDXW(6)
        ) u_dut (
            .clk(clk),
            .resetn(resetn),
            .start(start[g]),
            .busy(busy[g]),
            .done(done[g]),
            .cfg_idx(idx[g]),
            .cfg_word(cw[g]),
            .serial_clock(sc[g]),
            .serial_data(sd[g]),
            .serial_load(sl[g])
        );
        assign cw[g] = words[g][idx[g]];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Pad-chain model plus per-edge protocol checks, sampled mid-cycle.
    initial begin
        for (int k = 0; k < 3; k++) begin
            edges[k] = 0; hi_len[k] = 0; lo_len[k] = 0; ld_len[k] = 0;
            loads[k] = 0; dones[k] = 0; pidx[k] = '0;
            chain[k] = '0; latched[k] = '0;
        end
        psc = '0; psd = '0; psl = '0; pbusy = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                int e, pad, np, cd;
                np = np_of(k);
                cd = cd_of(k);
                if (busy[k] === 1'b1 && pbusy[k] === 1'b0) edges[k] = 0;
                if (sc[k] === 1'b1 && psc[k] === 1'b0) begin
                    e = edges[k];
                    chk("rise_data_stable", sd[k], psd[k]);
                    if (e > 0 && resetn)
                        chk("lo_len", lo_len[k], (e % 13 == 0) ? cd + 1 : cd);
                    pad = np - 1 - e / 13;
                    if (pad >= 0)
                        chk("bit", sd[k], words[k][pad][12 - e % 13]);
                    chain[k] = {chain[k][492:0], sd[k]};
                    edges[k]++;
                    lo_len[k] = 0;
                end
                if (sc[k] === 1'b1 && psc[k] === 1'b1)
                    chk("hi_data_stable", sd[k], psd[k]);
                if (sc[k] === 1'b1) begin
                    hi_len[k]++;
                end else begin
                    if (psc[k] === 1'b1) begin
                        if (resetn) chk("hi_len", hi_len[k], cd);
                        hi_len[k] = 0;
                    end
                    lo_len[k]++;
                end
                if (sl[k] === 1'b1 && psl[k] === 1'b0) latched[k] = chain[k];
                if (sl[k] === 1'b1) begin
                    ld_len[k]++;
                end else if (psl[k] === 1'b1) begin
                    if (resetn) chk("load_len", ld_len[k], cd);
                    loads[k]++;
                    ld_len[k] = 0;
                end
                if (done[k] === 1'b1) dones[k]++;
                if (resetn && idx[k] !== pidx[k])
                    chk("idx_step", idx[k],
                        (pidx[k] == 0) ? 6'(np - 1) : pidx[k] - 6'd1);
                psc[k] = sc[k];
                psd[k] = sd[k];
                psl[k] = sl[k];
                pbusy[k] = busy[k];
                pidx[k] = idx[k];
            end
        end
    end

    task automatic fill_rand(input int k);
        for (int p = 0; p < 38; p++) words[k][p] = 13'($urandom);
    endtask

    task automatic chk_latched(input int k, input string tag);
        for (int p = 0; p < np_of(k); p++)
            chk(tag, latched[k][p*13 +: 13], words[k][p]);
    endtask

    task automatic chk_idle_all(input string tag);
        for (int k = 0; k < 3; k++)
            chk(tag, {busy[k], done[k], sc[k], sd[k], sl[k], idx[k]}, 0);
    endtask

    task automatic run_seq(input int k, input bit inject);
        int n, l0, d0;
        bit hit;
        l0 = loads[k];
        d0 = dones[k];
        hit = 0;
        @(negedge clk);
        start[k] = 1'b1;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        n = 1;
        while (done[k] !== 1'b1 && n < 8000) begin
            if (inject && !hit && sc[k] === 1'b1) begin
                start[k] = 1'b1;
                hit = 1;
            end else begin
                start[k] = 1'b0;
            end
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, lat_of(k));
        chk("busy_in_done", busy[k], 1);
        start[k] = inject;
        @(posedge clk);
        #1;
        start[k] = 1'b0;
        chk("done_one_cycle", done[k], 0);
        chk("busy_clear", busy[k], 0);
        repeat (4) @(posedge clk);
        #1;
        chk("start_not_queued", busy[k], 0);
        chk("done_count", dones[k] - d0, 1);
        chk("load_count", loads[k] - l0, 1);
        chk("edge_count", edges[k], np_of(k) * 13);
        chk_latched(k, "latched");
    endtask

    initial begin
        int n, l0;
        #5_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, l0;
        start  = '0;
        resetn = 1'b1;
        for (int k = 0; k < 3; k++)
            for (int p = 0; p < 38; p++) words[k][p] = '0;
        #2 resetn = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            start = (i % 2 == 0) ? 3'b111 : 3'b000;
            #1 chk_idle_all("reset_outputs");
        end
        start = '0;
        #2 resetn = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk_idle_all("idle_after_reset");

        words[0][1] = 13'h1803;
        words[0][0] = 13'h0402;
        run_seq(0, 0);

        for (int p = 0; p < 38; p++) words[1][p] = 13'(p);
        run_seq(1, 0);

        fill_rand(0);
        run_seq(0, 1);
        fill_rand(0);
        run_seq(0, 0);

        fill_rand(2);
        run_seq(2, 0);

        for (int p = 0; p < 38; p++) prev_w[p] = words[1][p];
        fill_rand(1);
        l0 = loads[1];
        @(negedge clk);
        start[1] = 1'b1;
        @(posedge clk);
        #1 start[1] = 1'b0;
        n = 0;
        while (!(edges[1] == 227 && idx[1] == 6'd20) && n < 5000) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("abort_reached", n < 5000, 1);
        #1 resetn = 1'b0;
        #1 chk_idle_all("abort_outputs");
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;
        repeat (3) @(posedge clk);
        #1 chk("abort_no_load", loads[1] - l0, 0);
        chk_idle_all("abort_idle");
        for (int p = 0; p < 38; p++)
            chk("abort_retained", latched[1][p*13 +: 13], prev_w[p]);

        run_seq(1, 0);
        fill_rand(2);
        run_seq(2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
